serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
- Serial-to-parallel receiver: the receiving end of the serial link driven by the team's parallel-load shift-register transmitters.
- Samples one bit per clock-enable strobe while a frame qualifier is high, then assembles NBIT-bit words.
- Presents each completed word on a valid/ready output port with a one-word holding register.
- Flags overrun and framing errors with sticky bits.

Parameters:
- NBIT, 8, word width in bits (must be >= 2).
- MSB_FIRST, 1, 1: first received bit lands in data[NBIT-1]; 0: first received bit lands in data[0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  bit strobe; sdi and sframe are sampled only on clk edges where clk_en=1.
- sframe  in  1  frame qualifier; high for the NBIT bits of a word.
- sdi  in  1  serial data in.
- data  out  NBIT  received word (holding register).
- valid  out  1  data holds an unconsumed word.
- ready  in  1  consumer accepts data when valid & ready at a clk edge.
- overrun  out  1  sticky: a completed word was dropped because the holding register was full.
- frame_err  out  1  sticky: sframe fell before NBIT bits were received.
- err_clr  in  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0 (data, valid, overrun, frame_err); shift register and bit counter are 0; FSM is in IDLE. Reset mid-word discards the partial word.
- Internal state:
  - NBIT-bit shift register.
  - Bit counter, width $clog2(NBIT+1), range 0..NBIT-1.
  - Two-state FSM: IDLE, SHIFT.
- All sampling is gated by clk_en. With clk_en=0 the FSM, counter and shift register hold, but the output handshake and err_clr still act every clk edge.
- Bit insertion:
  - MSB_FIRST=1: shift left, sdi enters bit 0.
  - MSB_FIRST=0: shift right, sdi enters bit NBIT-1.
  - After NBIT bits, the first bit is therefore at data[NBIT-1] or data[0] respectively.
- IDLE:
  - On clk_en & sframe: sample sdi as bit 1, counter=1, go to SHIFT.
  - On clk_en & !sframe: stay in IDLE.
- SHIFT:
  - On clk_en & sframe: sample sdi and increment the counter.
  - When the sampled bit is the NBIT-th: the word completes, the counter goes to 0, and the FSM goes to IDLE.
  - The next sframe-qualified strobe starts a new word. Back-to-back frames need no gap.
  - On clk_en & !sframe before completion: discard the partial word, set frame_err, counter=0, go to IDLE.
- Word completion, evaluated at the same edge as the last bit:
  - If the slot is free, load data with the assembled word (including the bit sampled this edge) and set valid=1. valid is visible on the cycle after that edge, so latency is 1 clk from the final sample edge.
  - The slot is free if valid=0, or valid=1 & ready=1 at that same edge (the simultaneous pop and push is accepted).
  - Otherwise the word is dropped, data and valid are unchanged, and overrun is set.
- Handshake:
  - valid & ready at an edge with no simultaneous completion: valid goes to 0.
  - data is stable while valid=1 and is not updated until the word is consumed.
- ready is ignored while valid=0.
- err_clr=1 at an edge clears overrun and frame_err. A set event at the same edge wins, so the flag stays 1.
- NBIT=1 is not supported; an elaboration-time assertion enforces NBIT >= 2.

Test Plan:
- Basic word, NBIT=8, MSB_FIRST=1:
  - Stimulus: ready=0, clk_en every 4th clk, sframe high for 8 strobes, sdi=1,0,1,0,0,1,0,1.
  - Required: data=8'hA5 and valid=1 one clk after the 8th strobe edge. After ready pulses for 1 clk, valid=0.
- Bit order, MSB_FIRST=0:
  - Stimulus: same bit sequence 1,0,1,0,0,1,0,1.
  - Required: data=8'hA5 (bit-reversal of 10100101 equals itself). Then send 1,1,0,0,0,0,0,0: data=8'h03.
- Back-to-back with simultaneous pop/push:
  - Stimulus: two 8-bit frames 8'h3C and 8'hC3 with no gap, clk_en every clk. Hold ready=1 only on the edge completing the second frame.
  - Required: data=8'hC3, valid=1, overrun=0.
- Overrun:
  - Stimulus: ready=0, frames 8'h11 then 8'h22.
  - Required: data stays 8'h11, valid=1, overrun=1.
  - Then: err_clr pulse clears overrun to 0.
  - Then: err_clr asserted on the edge of a third dropped word leaves overrun=1.
- Framing error:
  - Stimulus: sframe drops after 5 strobes.
  - Required: frame_err=1, valid unchanged.
  - Then: a full frame 8'h5A is received correctly, with no stale bits in it.
- Reset mid-word:
  - Stimulus: assert rst_n=0 asynchronously after 4 bits.
  - Required: all outputs 0 immediately. After release, a full frame 8'hF0 is received as 8'hF0.

Source files
------------

// File: rtl/serial_rx.sv
// Serial-to-parallel receiver: assembles NBIT-bit words from a strobed, framed bit
// stream and presents them through a one-word valid/ready holding register.
module serial_rx #(
  parameter int NBIT      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            sframe,
  input  logic            sdi,
  output logic [NBIT-1:0] data,
  output logic            valid,
  input  logic            ready,
  output logic            overrun,
  output logic            frame_err,
  input  logic            err_clr
);

  localparam int CW = $clog2(NBIT + 1);

  if (NBIT < 2) begin : g_nbit_check
    $error("serial_rx: NBIT must be >= 2");
  end

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [NBIT-1:0] shift_q;
  logic [NBIT-1:0] shift_d;
  logic [NBIT-1:0] start_d;
  logic [NBIT-1:0] data_q;
  logic            valid_q;
  logic            overrun_q;
  logic            frame_err_q;
  logic            last_bit;
  logic            slot_free;

  // start_d begins a fresh word so no bits from an earlier frame can leak in
  always_comb begin
    shift_d = shift_q;
    start_d = '0;
    if (MSB_FIRST) begin
      shift_d = {shift_q[NBIT-2:0], sdi};
      start_d = {{(NBIT-1){1'b0}}, sdi};
    end else begin
      shift_d = {sdi, shift_q[NBIT-1:1]};
      start_d = {sdi, {(NBIT-1){1'b0}}};
    end
  end

  assign last_bit  = (cnt_q == CW'(NBIT - 1));
  assign slot_free = !valid_q || ready;

  // Later assignments override earlier ones, so completion beats pop and set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (err_clr) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      if (clk_en) begin
        case (state_q)
          IDLE: begin
            if (sframe) begin
              shift_q <= start_d;
              cnt_q   <= CW'(1);
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (sframe) begin
              shift_q <= shift_d;
              if (last_bit) begin
                cnt_q   <= '0;
                state_q <= IDLE;
                if (slot_free) begin
                  data_q  <= shift_d;
                  valid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else begin
              shift_q     <= '0;
              cnt_q       <= '0;
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed testbench for serial_rx: one MSB-first and one LSB-first instance
// share the same stimulus; expected values are hand-computed constants.
module tb_serial_rx;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic       sframe;
  logic       sdi;
  logic       ready;
  logic       err_clr;
  logic [7:0] data1;
  logic [7:0] data0;
  logic       valid1;
  logic       valid0;
  logic       overrun1;
  logic       overrun0;
  logic       frameErr1;
  logic       frameErr0;

  int vectors;
  int miscompares;

  serial_rx #(.NBIT(8), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sframe(sframe), .sdi(sdi),
    .data(data1), .valid(valid1), .ready(ready),
    .overrun(overrun1), .frame_err(frameErr1), .err_clr(err_clr)
  );

  serial_rx #(.NBIT(8), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sframe(sframe), .sdi(sdi),
    .data(data0), .valid(valid0), .ready(ready),
    .overrun(overrun0), .frame_err(frameErr0), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle 1 ns so registered outputs are sampled off the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic fr, input logic d,
                               input logic rdy, input logic clr);
    clk_en  = en;
    sframe  = fr;
    sdi     = d;
    ready   = rdy;
    err_clr = clr;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Sends w[7] first; ready/err_clr are asserted only on the final strobe edge
  task automatic sendWord(input logic [7:0] w, input int gap,
                          input logic rdyLast, input logic clrLast);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b1, w[i], (i == 0) ? rdyLast : 1'b0,
                    (i == 0) ? clrLast : 1'b0);
      if (i > 0) begin
        clk_en  = 1'b0;
        ready   = 1'b0;
        err_clr = 1'b0;
        repeat (gap) tick();
      end
    end
    clk_en  = 1'b0;
    sframe  = 1'b0;
    sdi     = 1'b0;
    ready   = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_en      = 1'b0;
    sframe      = 1'b0;
    sdi         = 1'b0;
    ready       = 1'b0;
    err_clr     = 1'b0;
    rst_n       = 1'b0;
    repeat (3) tick();

    checkOutput("reset_data", data1, 8'h00);
    checkOutput("reset_valid", {7'b0, valid1}, 8'h00);
    checkOutput("reset_overrun", {7'b0, overrun1}, 8'h00);
    checkOutput("reset_frame_err", {7'b0, frameErr1}, 8'h00);
    rst_n = 1'b1;
    tick();

    sendWord(8'hA5, 3, 1'b0, 1'b0);
    checkOutput("basic_data", data1, 8'hA5);
    checkOutput("basic_valid", {7'b0, valid1}, 8'h01);
    checkOutput("lsb_first_a5", data0, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("basic_pop_valid", {7'b0, valid1}, 8'h00);
    checkOutput("lsb_pop_valid", {7'b0, valid0}, 8'h00);

    sendWord(8'hC0, 0, 1'b0, 1'b0);
    checkOutput("lsb_first_03", data0, 8'h03);
    checkOutput("msb_first_c0", data1, 8'hC0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    sendWord(8'h3C, 0, 1'b0, 1'b0);
    checkOutput("b2b_first_data", data1, 8'h3C);
    sendWord(8'hC3, 0, 1'b1, 1'b0);
    checkOutput("b2b_data", data1, 8'hC3);
    checkOutput("b2b_valid", {7'b0, valid1}, 8'h01);
    checkOutput("b2b_overrun", {7'b0, overrun1}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_pop_valid", {7'b0, valid1}, 8'h00);

    sendWord(8'h11, 0, 1'b0, 1'b0);
    checkOutput("ovr_no_flag_yet", {7'b0, overrun1}, 8'h00);
    sendWord(8'h22, 0, 1'b0, 1'b0);
    checkOutput("ovr_data_held", data1, 8'h11);
    checkOutput("ovr_valid", {7'b0, valid1}, 8'h01);
    checkOutput("ovr_flag", {7'b0, overrun1}, 8'h01);
    checkOutput("ovr_flag_lsb", {7'b0, overrun0}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_cleared", {7'b0, overrun1}, 8'h00);
    sendWord(8'h33, 0, 1'b0, 1'b1);
    checkOutput("ovr_set_beats_clr", {7'b0, overrun1}, 8'h01);
    checkOutput("ovr_data_still", data1, 8'h11);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_final_valid", {7'b0, valid1}, 8'h00);
    checkOutput("ovr_final_flag", {7'b0, overrun1}, 8'h00);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ferr_flag", {7'b0, frameErr1}, 8'h01);
    checkOutput("ferr_valid", {7'b0, valid1}, 8'h00);
    clk_en = 1'b0;
    sendWord(8'h5A, 0, 1'b0, 1'b0);
    checkOutput("ferr_recover_data", data1, 8'h5A);
    checkOutput("ferr_recover_valid", {7'b0, valid1}, 8'h01);
    checkOutput("ferr_still_sticky", {7'b0, frameErr1}, 8'h01);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_data", data1, 8'h00);
    checkOutput("rst_mid_valid", {7'b0, valid1}, 8'h00);
    checkOutput("rst_mid_frame_err", {7'b0, frameErr1}, 8'h00);
    checkOutput("rst_mid_overrun", {7'b0, overrun1}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    sendWord(8'hF0, 0, 1'b0, 1'b0);
    checkOutput("rst_after_data", data1, 8'hF0);
    checkOutput("rst_after_valid", {7'b0, valid1}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
